writeback_unit: RTL

Collects four-lane result bundles from the execute stage, filters them, buffers them in a bundle FIFO and drives the register file's four writeback ports (back_1..4_vld/des/data) one bundle per cycle. It sits on the write side of the register file, between execute and the register file. It guarantees program-order-correct writes: it resolves same-destination conflicts inside a bundle, suppresses writes to reg0, and exports a pending-destination mask so that issue logic can stall on in-flight writes.

---
 rtl/writeback_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | writeback_unit: filters 4-lane execute bundles, queues them in a FIFO and |
// | drives the register-file writeback ports. Option macro: WB_BYPASS_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_ready,
  input  logic                     in_1_vld,
  input  logic [3:0]               in_1_des,
  input  logic [31:0]              in_1_data,
  input  logic                     in_2_vld,
  input  logic [3:0]               in_2_des,
  input  logic [31:0]              in_2_data,
  input  logic                     in_3_vld,
  input  logic [3:0]               in_3_des,
  input  logic [31:0]              in_3_data,
  input  logic                     in_4_vld,
  input  logic [3:0]               in_4_des,
  input  logic [31:0]              in_4_data,
  input  logic                     hold,
  output logic                     back_1_vld,
  output logic [3:0]               back_1_des,
  output logic [31:0]              back_1_data,
  output logic                     back_2_vld,
  output logic [3:0]               back_2_des,
  output logic [31:0]              back_2_data,
  output logic                     back_3_vld,
  output logic [3:0]               back_3_des,
  output logic [31:0]              back_3_data,
  output logic                     back_4_vld,
  output logic [3:0]               back_4_des,
  output logic [31:0]              back_4_data,
  output logic [15:0]              pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]        w_in_vld;
  logic [3:0][3:0]   w_in_des;
  logic [3:0][31:0]  w_in_data;
  logic [3:0]        w_flt_vld;

  logic              w_accept;
  logic              w_nonempty;
  logic              w_push;
  logic              w_pop;
  logic              w_bypass;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic [3:0]        r_mem_vld  [DEPTH];
  logic [3:0][3:0]   r_mem_des  [DEPTH];
  logic [3:0][31:0]  r_mem_data [DEPTH];

  logic [3:0]        r_back_vld;
  logic [3:0][3:0]   r_back_des;
  logic [3:0][31:0]  r_back_data;

  logic [15:0]       w_pending;
  logic [AW-1:0]     w_idx;

  assign w_in_vld  = {in_4_vld, in_3_vld, in_2_vld, in_1_vld};
  assign w_in_des  = {in_4_des, in_3_des, in_2_des, in_1_des};
  assign w_in_data = {in_4_data, in_3_data, in_2_data, in_1_data};

  // A lane survives only if it targets a real register and no younger lane
  // in the same bundle writes the same register.
  for (genvar i = 0; i < 4; i++) begin : g_filter
    logic w_younger_hit;
    always_comb begin
      w_younger_hit = 1'b0;
      for (int j = i + 1; j < 4; j++) begin
        if (w_in_vld[j] && (w_in_des[j] == w_in_des[i])) begin
          w_younger_hit = 1'b1;
        end
      end
    end
    assign w_flt_vld[i] = w_in_vld[i] && (w_in_des[i] != 4'd0) && !w_younger_hit;
  end

  assign in_ready   = (r_count != CW'(DEPTH));
  assign w_accept   = in_vld && in_ready;
  assign w_nonempty = |w_flt_vld;
  assign w_pop      = !hold && (r_count != '0);

`ifdef WB_BYPASS_EN
  assign w_bypass = w_accept && w_nonempty && (r_count == '0) && !hold;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept && w_nonempty && !w_bypass;

  // Payload storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_vld[r_wr_ptr]  <= w_flt_vld;
      r_mem_des[r_wr_ptr]  <= w_in_des;
      r_mem_data[r_wr_ptr] <= w_in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_back_vld  <= '0;
      r_back_des  <= '0;
      r_back_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      if (w_pop) begin
        r_back_vld  <= r_mem_vld[r_rd_ptr];
        r_back_des  <= r_mem_des[r_rd_ptr];
        r_back_data <= r_mem_data[r_rd_ptr];
      end else if (w_bypass) begin
        r_back_vld  <= w_flt_vld;
        r_back_des  <= w_in_des;
        r_back_data <= w_in_data;
      end else begin
        r_back_vld  <= '0;
      end
    end
  end

  // Scan only occupied slots, walking forward from the head.
  always_comb begin
    w_pending = '0;
    w_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < r_count) begin
        w_idx = r_rd_ptr + AW'(k);
        for (int l = 0; l < 4; l++) begin
          if (r_mem_vld[w_idx][l]) begin
            w_pending[r_mem_des[w_idx][l]] = 1'b1;
          end
        end
      end
    end
    for (int l = 0; l < 4; l++) begin
      if (r_back_vld[l]) begin
        w_pending[r_back_des[l]] = 1'b1;
      end
    end
    w_pending[0] = 1'b0;
  end

  assign pending     = w_pending;
  assign count       = r_count;

  assign back_1_vld  = r_back_vld[0];
  assign back_1_des  = r_back_des[0];
  assign back_1_data = r_back_data[0];
  assign back_2_vld  = r_back_vld[1];
  assign back_2_des  = r_back_des[1];
  assign back_2_data = r_back_data[1];
  assign back_3_vld  = r_back_vld[2];
  assign back_3_des  = r_back_des[2];
  assign back_3_data = r_back_data[2];
  assign back_4_vld  = r_back_vld[3];
  assign back_4_des  = r_back_des[3];
  assign back_4_data = r_back_data[3];

endmodule
`default_nettype wire
